// File: rtl/counter_milli_down.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : counter_milli_down                                            |
// | Brief    : 4-digit BCD countdown timer with load, pair adjust, expiry.   |
// |            Optional macro COUNTER_DOWN_REPEAT_EN enables auto-reload.    |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module counter_milli_down (
  input  logic        clk_used,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        adj,
  input  logic        sel,
  input  logic        adj_step,
  input  logic        is_running,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4,
  output logic        done,
  output logic        running
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_digits;
  logic [15:0] w_digits_nxt;
  logic [15:0] r_preset;
  logic [15:0] w_preset_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        w_adj_hit;
  logic [15:0] w_adj_val;

  function automatic logic [15:0] f_clamp(input logic [15:0] v);
    logic [15:0] res;
    res = '0;
    for (int i = 0; i < 4; i++)
      res[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd9 : v[i*4 +: 4];
    return res;
  endfunction

  // Two-digit BCD increment, 99 wraps to 00 without carrying out.
  function automatic logic [7:0] f_pair_inc(input logic [7:0] p);
    logic [7:0] res;
    if (p[3:0] == 4'd9) begin
      if (p[7:4] == 4'd9) res = 8'h00;
      else                res = {p[7:4] + 4'd1, 4'd0};
    end else begin
      res = {p[7:4], p[3:0] + 4'd1};
    end
    return res;
  endfunction

  function automatic logic [15:0] f_dec(input logic [15:0] v);
    logic [15:0] res;
    logic        borrow;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          res[i*4 +: 4] = 4'd9;
        end else begin
          res[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

  assign w_adj_hit = adj & adj_step & (r_state != S_RUN);
  assign w_adj_val = sel ? {f_pair_inc(r_digits[15:8]), r_digits[7:0]}
                         : {r_digits[15:8], f_pair_inc(r_digits[7:0])};

  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_preset_nxt = r_preset;
`ifdef COUNTER_DOWN_REPEAT_EN
    w_done_nxt   = 1'b0;
`else
    w_done_nxt   = r_done;
`endif
    if (load) begin
      w_digits_nxt = f_clamp(load_value);
      w_preset_nxt = f_clamp(load_value);
      w_state_nxt  = S_IDLE;
      w_done_nxt   = 1'b0;
    end else if (w_adj_hit) begin
      w_digits_nxt = w_adj_val;
      w_preset_nxt = w_adj_val;
      w_state_nxt  = S_IDLE;
      w_done_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (is_running && (r_digits != 16'h0000))
            w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!is_running) begin
            w_state_nxt = S_IDLE;
          end else if (r_digits == 16'h0001) begin
`ifdef COUNTER_DOWN_REPEAT_EN
            w_digits_nxt = r_preset;
            w_done_nxt   = (r_preset != 16'h0000);
`else
            w_digits_nxt = 16'h0000;
            w_state_nxt  = S_EXPIRED;
            w_done_nxt   = 1'b1;
`endif
          end else if (r_digits != 16'h0000) begin
            w_digits_nxt = f_dec(r_digits);
          end
        end
        S_EXPIRED: begin
          w_digits_nxt = 16'h0000;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_used) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_digits <= 16'h0000;
      r_preset <= 16'h0000;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_digits <= w_digits_nxt;
      r_preset <= w_preset_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign digit1  = r_digits[15:12];
  assign digit2  = r_digits[11:8];
  assign digit3  = r_digits[7:4];
  assign digit4  = r_digits[3:0];
  assign done    = r_done;
  assign running = (r_state == S_RUN);

endmodule
`default_nettype wire
